// File: rtl/router_mon_pkg.sv
// Shared definitions for the router link monitor: error-flag bit layout,
// framing FSM states and link index helpers.
package router_mon_pkg;

  localparam int ERR_UNSTABLE  = 0;
  localparam int ERR_WITHDRAW  = 1;
  localparam int ERR_ZERO_SIZE = 2;
  localparam int ERR_STALL     = 3;
  localparam int ERR_BITS      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SIZE,
    PAYLOAD
  } frame_state_e;

  // Link p watches the input side of port p; link nports+p watches its output side.
  function automatic int in_link(input int port);
    return port;
  endfunction

  function automatic int out_link(input int nports, input int port);
    return nports + port;
  endfunction

endpackage

// File: rtl/link_monitor.sv
// Per-link checker: packet framing FSM, credit handshake checks, sticky
// error flags and a saturating completed-packet counter.
module link_monitor
  import router_mon_pkg::*;
#(
  parameter int FLIT_WIDTH = 16,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic                  credit,
  input  logic [FLIT_WIDTH-1:0] data,
  input  logic                  clear,
  output logic [ERR_BITS-1:0]   flags,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

  frame_state_e          state_q, state_d;
  logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  wait_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic                  complete, zero_det;
  logic [ERR_BITS-1:0]   det;

  logic xfer, blocked;
  assign xfer    = valid & credit;
  assign blocked = valid & ~credit;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    remaining_d = remaining_q;
    complete    = 1'b0;
    zero_det    = 1'b0;
    case (state_q)
      IDLE:    if (xfer) state_d = SIZE;
      SIZE: begin
        if (xfer) begin
          if (data == '0) begin
            zero_det = 1'b1;
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            remaining_d = data;
            state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          remaining_d = remaining_q - FLIT_WIDTH'(1);
          if (remaining_q == FLIT_WIDTH'(1)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter parks at TIMEOUT instead of wrapping.
  assign stall_d = blocked ? ((stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1))
                           : '0;

  assign det[ERR_UNSTABLE]  = wait_q & valid & (data != data_q);
  assign det[ERR_WITHDRAW]  = wait_q & ~valid;
  assign det[ERR_ZERO_SIZE] = zero_det;
  assign det[ERR_STALL]     = blocked & (stall_d == STALL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      stall_q     <= '0;
      wait_q      <= 1'b0;
      data_q      <= '0;
      flags       <= '0;
      done        <= 1'b0;
      count       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= blocked;
      data_q      <= data;
      if (clear) begin
        flags   <= '0;
        done    <= 1'b0;
        count   <= '0;
        stall_q <= '0;
      end else begin
        flags   <= flags | det;
        done    <= complete;
        stall_q <= stall_d;
        if (complete && count != '1) count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/router_link_monitor.sv
// Passive protocol monitor for all input and output links of an NPORTS
// credit-based router; one link_monitor per link plus a registered err_any.
module router_link_monitor
  import router_mon_pkg::*;
#(
  parameter int FLIT_WIDTH = 16,
  parameter int NPORTS     = 5,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NPORTS-1:0]              rx,
  input  logic [NPORTS*FLIT_WIDTH-1:0]   data_in,
  input  logic [NPORTS-1:0]              credit_o,
  input  logic [NPORTS-1:0]              tx,
  input  logic [NPORTS*FLIT_WIDTH-1:0]   data_out,
  input  logic [NPORTS-1:0]              credit_i,
  input  logic                           clear,
  output logic [2*NPORTS*ERR_BITS-1:0]   err_flags,
  output logic                           err_any,
  output logic [2*NPORTS-1:0]            pkt_done,
  output logic [2*NPORTS*CNT_WIDTH-1:0]  pkt_count
);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    localparam int LI = in_link(p);
    localparam int LO = out_link(NPORTS, p);

    link_monitor #(
      .FLIT_WIDTH(FLIT_WIDTH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
    ) u_in (
      .clk   (clock),
      .rst_n (reset),
      .valid (rx[p]),
      .credit(credit_o[p]),
      .data  (data_in[p*FLIT_WIDTH +: FLIT_WIDTH]),
      .clear (clear),
      .flags (err_flags[LI*ERR_BITS +: ERR_BITS]),
      .done  (pkt_done[LI]),
      .count (pkt_count[LI*CNT_WIDTH +: CNT_WIDTH])
    );

    link_monitor #(
      .FLIT_WIDTH(FLIT_WIDTH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
    ) u_out (
      .clk   (clock),
      .rst_n (reset),
      .valid (tx[p]),
      .credit(credit_i[p]),
      .data  (data_out[p*FLIT_WIDTH +: FLIT_WIDTH]),
      .clear (clear),
      .flags (err_flags[LO*ERR_BITS +: ERR_BITS]),
      .done  (pkt_done[LO]),
      .count (pkt_count[LO*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     err_any <= 1'b0;
    else if (clear) err_any <= 1'b0;
    else            err_any <= |err_flags;
  end

endmodule

// File: tb/tb_router_link_monitor.sv
// Directed bench for router_link_monitor: a queue scoreboard checks every
// pkt_done pulse, while the stimulus thread checks flags and counters.
module tb_router_link_monitor;
  import router_mon_pkg::*;

  localparam int NP = 5;
  localparam int FW = 16;
  localparam int CW = 16;
  localparam int TO = 1024;
  localparam int NL = 2 * NP;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NP-1:0]         rx = '0, credit_o = '0, tx = '0, credit_i = '0;
  logic [NP*FW-1:0]      data_in = '0, data_out = '0;
  logic                  clear = 1'b0;
  logic [NL*ERR_BITS-1:0] err_flags;
  logic                  err_any;
  logic [NL-1:0]         pkt_done;
  logic [NL*CW-1:0]      pkt_count;

  router_link_monitor #(
    .FLIT_WIDTH(FW), .NPORTS(NP), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_in(data_in), .credit_o(credit_o),
    .tx(tx), .data_out(data_out), .credit_i(credit_i), .clear(clear),
    .err_flags(err_flags), .err_any(err_any), .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int          link;
    int          count;
    int unsigned cycle;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt[NL];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic flag(input int l, input int b);
    return err_flags[l*ERR_BITS + b];
  endfunction

  function automatic logic [CW-1:0] cnt(input int l);
    return pkt_count[l*CW +: CW];
  endfunction

  // Scoreboard monitor: every pkt_done pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      for (int l = 0; l < NL; l++) begin
        if (pkt_done[l]) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected pkt_done on link %0d at cycle %0d", l, cyc);
          end else begin
            e = sb.pop_front();
            check($sformatf("done_link@%0d", cyc), 64'(l), 64'(e.link));
            check($sformatf("done_count_l%0d", l), 64'(cnt(l)), 64'(e.count));
            check($sformatf("done_cycle_l%0d", l), 64'(cyc), 64'(e.cycle));
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_link(input int l, input logic v, input logic c, input logic [FW-1:0] d);
    if (l < NP) begin
      rx[l] = v; credit_o[l] = c; data_in[l*FW +: FW] = d;
    end else begin
      tx[l-NP] = v; credit_i[l-NP] = c; data_out[(l-NP)*FW +: FW] = d;
    end
  endtask

  task automatic idle_all();
    rx = '0; credit_o = '0; tx = '0; credit_i = '0; data_in = '0; data_out = '0;
  endtask

  // The completing edge is the next posedge; pkt_done is seen one cycle later.
  task automatic expect_done(input int l);
    exp_t e;
    exp_cnt[l]++;
    e.link  = l;
    e.count = exp_cnt[l];
    e.cycle = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input int l, input logic [FW-1:0] hdr, input logic [FW-1:0] sz);
    set_link(l, 1'b1, 1'b1, hdr);
    step();
    set_link(l, 1'b1, 1'b1, sz);
    if (sz == '0) expect_done(l);
    step();
    for (int i = 0; i < int'(sz); i++) begin
      set_link(l, 1'b1, 1'b1, FW'(16'h0100 + i));
      if (i == int'(sz) - 1) expect_done(l);
      step();
    end
    set_link(l, 1'b0, 1'b1, '0);
  endtask

  task automatic zero_model();
    for (int l = 0; l < NL; l++) exp_cnt[l] = 0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    zero_model();
  endtask

  initial begin
    zero_model();
    repeat (3) step();
    check("reset_flags", 64'(err_flags), 64'(0));
    check("reset_done", 64'(pkt_done), 64'(0));
    check("reset_count", 64'(pkt_count), 64'(0));
    check("reset_err_any", 64'(err_any), 64'(0));
    reset = 1'b1;
    step();

    // Single packet on input link 0.
    send_pkt(0, 16'h0011, 16'h0003);
    repeat (3) step();
    check("l0_count", 64'(cnt(0)), 64'(1));
    check("l0_flags", 64'(err_flags), 64'(0));

    // Stall on output link 2 (link 7); dropping valid in the clear cycle is lost.
    set_link(7, 1'b1, 1'b0, 16'h1234);
    repeat (TO - 1) step();
    check("l7_stall_before", 64'(flag(7, ERR_STALL)), 64'(0));
    step();
    check("l7_stall_at_timeout", 64'(flag(7, ERR_STALL)), 64'(1));
    check("l7_err_any_lag", 64'(err_any), 64'(0));
    step();
    check("l7_err_any", 64'(err_any), 64'(1));
    check("l7_only_stall", 64'(err_flags), 64'(1) << (7*ERR_BITS + ERR_STALL));
    set_link(7, 1'b0, 1'b0, '0);
    pulse_clear();
    check("clear_flags", 64'(err_flags), 64'(0));
    check("clear_err_any", 64'(err_any), 64'(0));
    check("clear_count", 64'(pkt_count), 64'(0));

    // Unstable then withdraw on input link 1.
    set_link(1, 1'b1, 1'b0, 16'hAAAA);
    step();
    set_link(1, 1'b1, 1'b0, 16'h5555);
    step();
    check("l1_unstable", 64'(flag(1, ERR_UNSTABLE)), 64'(1));
    check("l1_no_withdraw", 64'(flag(1, ERR_WITHDRAW)), 64'(0));
    pulse_clear();
    check("l1_cleared", 64'(err_flags), 64'(0));
    set_link(1, 1'b0, 1'b0, 16'h5555);
    step();
    check("l1_withdraw", 64'(flag(1, ERR_WITHDRAW)), 64'(1));
    check("l1_no_unstable", 64'(flag(1, ERR_UNSTABLE)), 64'(0));
    step();
    check("l1_err_any", 64'(err_any), 64'(1));
    pulse_clear();

    // Zero-size packet on link 3 followed by a normal packet.
    send_pkt(3, 16'h00AA, 16'h0000);
    step();
    check("l3_zero_size", 64'(err_flags), 64'(1) << (3*ERR_BITS + ERR_ZERO_SIZE));
    check("l3_count_1", 64'(cnt(3)), 64'(1));
    send_pkt(3, 16'h00BB, 16'h0001);
    repeat (2) step();
    check("l3_count_2", 64'(cnt(3)), 64'(2));

    // Back-to-back size-1 packets on link 4.
    send_pkt(4, 16'h0044, 16'h0001);
    send_pkt(4, 16'h0045, 16'h0001);
    repeat (2) step();
    check("l4_count", 64'(cnt(4)), 64'(2));
    check("sb_drained_mid", 64'(sb.size()), 64'(0));

    // Asynchronous reset in mid-payload on link 6, then a fresh packet.
    set_link(6, 1'b1, 1'b1, 16'h0077);
    step();
    set_link(6, 1'b1, 1'b1, 16'h0003);
    step();
    set_link(6, 1'b1, 1'b1, 16'h0100);
    step();
    #2 reset = 1'b0;
    idle_all();
    #1;
    check("rst_flags", 64'(err_flags), 64'(0));
    check("rst_err_any", 64'(err_any), 64'(0));
    check("rst_done", 64'(pkt_done), 64'(0));
    check("rst_count", 64'(pkt_count), 64'(0));
    zero_model();
    step();
    reset = 1'b1;
    step();
    send_pkt(6, 16'h0042, 16'h0002);
    repeat (2) step();
    check("l6_count", 64'(cnt(6)), 64'(1));
    check("l6_flags", 64'(err_flags), 64'(0));

    repeat (3) step();
    check("sb_drained_end", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_link_monitor.md
Name: router_link_monitor

Overview:
- Parametrised, synthesizable protocol monitor for credit-based router links. It supersedes the fixed five-port bound property set.
- Watches every input link (rx/data_in/credit_o) and every output link (tx/data_out/credit_i) of an NPORTS router.
- Tracks packet framing (header, size, payload) and the credit handshake on each link.
- Raises sticky per-link error flags and counts completed packets. It runs in simulation and on FPGA debug builds.

Parameters:
- FLIT_WIDTH, 16, flit width in bits.
- NPORTS, 5, router port count. The block monitors 2*NPORTS links (index p = input of port p; index NPORTS+p = output of port p).
- TIMEOUT, 1024, maximum consecutive cycles with valid high and credit low before a stall error is flagged.
- CNT_WIDTH, 16, width of each per-link packet counter.

Ports:
- clock  in  1  monitor clock (same as router clock)
- reset  in  1  asynchronous, active-low reset
- rx  in  NPORTS  input-link valid
- data_in  in  NPORTS*FLIT_WIDTH  input-link flits, port 0 at the LSBs
- credit_o  in  NPORTS  input-link credit
- tx  in  NPORTS  output-link valid
- data_out  in  NPORTS*FLIT_WIDTH  output-link flits
- credit_i  in  NPORTS  output-link credit
- clear  in  1  synchronous clear of error flags and counters
- err_flags  out  2*NPORTS*4  sticky per-link {stall, zero_size, withdraw, unstable}, link 0 at the LSBs
- err_any  out  1  OR of all err_flags
- pkt_done  out  2*NPORTS  one-cycle pulse when a link completes a packet
- pkt_count  out  2*NPORTS*CNT_WIDTH  completed packets per link, saturating

Behaviour:
- Reset (reset=0, asynchronous): all FSMs go to IDLE; all counters, flags, pkt_done and pkt_count are 0; err_any=0.
- Transfer on a link = valid & credit in the same rising edge. All checks are per link and independent.
- Framing FSM per link:
  - IDLE -> SIZE on a transfer (header flit). The header value is ignored.
  - SIZE -> PAYLOAD on a transfer. The flit value is loaded into the remaining counter (FLIT_WIDTH bits).
  - SIZE, size flit = 0 -> set zero_size, go to IDLE, pulse pkt_done, increment pkt_count.
  - PAYLOAD: each transfer decrements remaining. The transfer that takes remaining from 1 to 0 returns to IDLE, pulses pkt_done and increments pkt_count.
  - Back-to-back packets are legal: the header may transfer in the cycle after the last payload flit.
- pkt_done is registered: it is high in the cycle after the completing edge.
- pkt_count saturates at all-ones and never wraps.
- unstable: valid was high and credit low at the previous edge, valid is still high, and data differs from the previous cycle. One-cycle detection latency.
- withdraw: valid was high and credit low at the previous edge, and valid is now low.
- stall:
  - Counter increments each cycle valid=1 and credit=0.
  - It clears on a transfer or when valid=0.
  - The flag sets when the counter reaches TIMEOUT. The counter then holds; it does not wrap.
- Flags are sticky. err_any is registered: one cycle after a flag's set edge.
- clear=1:
  - Zeroes flags, counters, pkt_done and stall counters at the next edge.
  - FSM state is preserved, so an in-flight packet still completes and counts after clear.
  - An error detected in the same cycle as clear is lost (clear wins).
- Simultaneous events on one link: each flag sets independently; a completion and an error may occur in the same cycle.
- Monitor-only: there are no outputs toward the router, and the block must not alter any router signal.

Decomposition:
- Package router_mon_pkg holds:
  - flag bit indices (ERR_UNSTABLE=0, ERR_WITHDRAW=1, ERR_ZERO_SIZE=2, ERR_STALL=3) and ERR_BITS=4;
  - the FSM state enum (IDLE, SIZE, PAYLOAD);
  - the link index helper constants.
- Sub-module link_monitor: one instance per link, generated 2*NPORTS times. It contains the FSM, remaining counter, stall counter, previous-cycle registers, flags and packet counter.
- The top level does only slicing, generate loops and the err_any reduction.

Test Plan:
- Input link 0, credit always 1; send header 0x0011, size 0x0003, then 3 payload flits -> pkt_done[0] pulses once, one cycle after the last flit. pkt_count[0]=1; err_flags=0.
- Output link 2 (index NPORTS+2=7): valid held with credit=0 for 1024 cycles -> err_flags stall bit of link 7 set exactly at the TIMEOUT count. err_any=1 one cycle later. Then clear=1 -> all zero.
- Input link 1: valid high, credit low, data changes 0xAAAA->0x5555 -> unstable bit of link 1 set. Same setup but valid dropped instead -> withdraw set.
- Size flit 0x0000 on link 3 -> zero_size set. FSM returns to IDLE; the next header starts a new packet normally; pkt_count[3]=1 after the zero-size packet.
- Two back-to-back packets (size 1 each) on link 4 with no idle cycle -> two pkt_done pulses, pkt_count[4]=2.
- Assert reset low in mid-payload -> all outputs 0 immediately. Restart with a fresh packet -> counted correctly; no spurious error flags.
